// File: rtl/ram_fill_verify_pkg.sv
// Shared constants for the RAM fill/verify driver: FSM encodings, pattern modes and LFSR setup.
// The optional LFSR pattern is built only when FILL_LFSR_EN is defined.
package ram_fill_verify_pkg;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StFill   = 2'd1;
  localparam logic [1:0] StVerify = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [1:0] ModeConst    = 2'd0;
  localparam logic [1:0] ModeInc      = 2'd1;
  localparam logic [1:0] ModeLfsr     = 2'd2;
  localparam logic [1:0] ModeConstAlt = 2'd3;

  // Taps 16,14,13,11 in 1-based numbering, i.e. bits 15,13,12,10.
  localparam logic [15:0] LfsrTaps        = 16'hB400;
  localparam logic [15:0] LfsrDefaultSeed = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LfsrTaps)};
  endfunction

endpackage

// File: rtl/ram_fill_verify_pattern_gen.sv
// Data pattern generator: load captures seed/mode, restart replays from word 0, step advances.
// Mode 2 is an LFSR only with FILL_LFSR_EN defined; otherwise it is a constant like mode 0.
module ram_fill_verify_pattern_gen
  import ram_fill_verify_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          restart_i,
  input  logic          step_i,
  input  logic [1:0]    mode_i,
  input  logic [DW-1:0] seed_i,
  output logic [DW-1:0] value_o
);

  logic [1:0]    mode_q, mode_d;
  logic [DW-1:0] seed_q, seed_d;
  logic [DW-1:0] value_q, value_d;
  logic [DW-1:0] init_seed;
  logic [DW-1:0] init_value;
`ifdef FILL_LFSR_EN
  logic [1:0]    init_mode;
`endif

  always_comb begin
    mode_d     = mode_q;
    seed_d     = seed_q;
    value_d    = value_q;
    init_seed  = load_i ? seed_i : seed_q;
    init_value = init_seed;
`ifdef FILL_LFSR_EN
    init_mode  = load_i ? mode_i : mode_q;
    // An all-zero LFSR state would lock up.
    if (init_mode == ModeLfsr && init_seed == '0) init_value = DW'(LfsrDefaultSeed);
`endif
    if (load_i) begin
      mode_d = mode_i;
      seed_d = seed_i;
    end
    if (load_i || restart_i) begin
      value_d = init_value;
    end else if (step_i) begin
      if (mode_q == ModeInc) value_d = value_q + DW'(1);
`ifdef FILL_LFSR_EN
      else if (mode_q == ModeLfsr) value_d = DW'(lfsr_next(16'(value_q)));
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q  <= ModeConst;
      seed_q  <= '0;
      value_q <= '0;
    end else begin
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/ram_fill_verify.sv
// Fills a RAM address range with a generated pattern, reads it back and counts mismatches.
// Define FILL_LFSR_EN to enable the LFSR pattern for mode 2.
module ram_fill_verify
  import ram_fill_verify_pkg::*;
#(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   count,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] seed,
  output logic [DW-1:0] mem_in,
  output logic [AW-1:0] mem_address,
  output logic          mem_load,
  input  logic [DW-1:0] mem_out,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] err_address,
  output logic [AW:0]   err_count
);

  localparam logic [AW:0] Words   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] OneWord = (AW+1)'(1);

  logic [1:0]    state_q, state_d;
  logic [AW:0]   offset_q, offset_d;
  logic [AW:0]   total_q, total_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          load_q, load_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [AW-1:0] err_addr_q, err_addr_d;
  logic [AW:0]   err_cnt_q, err_cnt_d;

  logic          gen_load, gen_restart, gen_step;
  logic [DW-1:0] pattern;
  logic [AW:0]   count_sat;
  logic          last;

  assign count_sat = (count > Words) ? Words : count;
  assign last      = (offset_q == total_q - OneWord);

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    total_d     = total_q;
    base_d      = base_q;
    addr_d      = addr_q;
    load_d      = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    error_d     = error_q;
    err_addr_d  = err_addr_q;
    err_cnt_d   = err_cnt_q;
    gen_load    = 1'b0;
    gen_restart = 1'b0;
    gen_step    = 1'b0;

    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            gen_load   = 1'b1;
            total_d    = count_sat;
            base_d     = base;
            addr_d     = base;
            offset_d   = '0;
            error_d    = 1'b0;
            err_addr_d = '0;
            err_cnt_d  = '0;
            if (count_sat == '0) begin
              state_d = StDone;
            end else begin
              state_d = StFill;
              load_d  = 1'b1;
              busy_d  = 1'b1;
            end
          end
        end
        StFill: begin
          gen_step = 1'b1;
          busy_d   = 1'b1;
          if (last) begin
            state_d     = StVerify;
            offset_d    = '0;
            addr_d      = base_q;
            gen_restart = 1'b1;
          end else begin
            offset_d = offset_q + OneWord;
            addr_d   = addr_q + AW'(1);
            load_d   = 1'b1;
          end
        end
        StVerify: begin
          gen_step = 1'b1;
          if (mem_out != pattern) begin
            error_d   = 1'b1;
            err_cnt_d = err_cnt_q + OneWord;
            if (!error_q) err_addr_d = addr_q;
          end
          if (last) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            offset_d = offset_q + OneWord;
            addr_d   = addr_q + AW'(1);
            busy_d   = 1'b1;
          end
        end
        StDone: begin
          // Stay until the done pulse has been issued; a zero-count run waits one extra cycle.
          if (done_q) state_d = StIdle;
          else        done_d  = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      offset_q   <= '0;
      total_q    <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      total_q    <= total_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  ram_fill_verify_pattern_gen #(
    .DW(DW)
  ) u_pattern_gen (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .load_i   (gen_load),
    .restart_i(gen_restart),
    .step_i   (gen_step),
    .mode_i   (mode),
    .seed_i   (seed),
    .value_o  (pattern)
  );

  assign mem_in      = pattern;
  assign mem_address = addr_q;
  assign mem_load    = load_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_address = err_addr_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_ram_fill_verify.sv
// Bench for ram_fill_verify paired with a behavioural 4K x 16 RAM and a reference memory image.
// Honours FILL_LFSR_EN for the mode 2 expectations.
module tb_ram_fill_verify;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] base = '0;
  logic [12:0] count = '0;
  logic [1:0]  mode = '0;
  logic [15:0] seed = '0;
  logic [15:0] mem_in;
  logic [11:0] mem_address;
  logic        mem_load;
  logic [15:0] mem_out;
  logic        busy, done, error;
  logic [11:0] err_address;
  logic [12:0] err_count;

  logic [15:0] ram [4096];
  logic [15:0] exp_ram [4096];
  bit          init_req = 1'b1;
  bit          fault_en = 1'b0;
  logic [11:0] fault_addr = '0;
  int          cyc = 0, writes = 0, compares = 0, done_cnt = 0, done_cyc = 0;
  int          checks = 0, errors = 0;

  ram_fill_verify dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .base       (base),
    .count      (count),
    .mode       (mode),
    .seed       (seed),
    .mem_in     (mem_in),
    .mem_address(mem_address),
    .mem_load   (mem_load),
    .mem_out    (mem_out),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_address(err_address),
    .err_count  (err_count)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] init_word(input int i);
    return 16'(i * 7 + 3) ^ 16'h3C5A;
  endfunction

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (init_req) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_word(i);
    end else if (mem_load) begin
      ram[mem_address] <= mem_in;
    end
  end

  // Fault injection forces a zero read at one address during read-back only.
  assign mem_out = (fault_en && busy && !mem_load && mem_address == fault_addr) ? 16'h0
                                                                                : ram[mem_address];

  always @(negedge clock) begin
    if (mem_load) writes <= writes + 1;
    if (busy && !mem_load) compares <= compares + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_case(input string tag, input logic [11:0] b, input logic [12:0] c,
                          input logic [1:0] m, input logic [15:0] s, input bit flt,
                          input logic [11:0] faddr, input bit bump);
    int n, w0, c0, d0, c_st, guard, exp_errs, bad;
    logic [11:0] a, exp_eaddr;
    logic [15:0] v;
    n = (c > 13'd4096) ? 4096 : int'(c);
    v = s;
`ifdef FILL_LFSR_EN
    if (m == 2'd2 && s == 16'h0) v = 16'hACE1;
`endif
    exp_errs  = 0;
    exp_eaddr = '0;
    for (int k = 0; k < n; k++) begin
      a = b + 12'(k);
      exp_ram[a] = v;
      if (flt && a == faddr && v != 16'h0) begin
        if (exp_errs == 0) exp_eaddr = a;
        exp_errs++;
      end
      if (m == 2'd1) v = v + 16'd1;
`ifdef FILL_LFSR_EN
      else if (m == 2'd2) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
`endif
    end
    fault_en   = flt;
    fault_addr = faddr;
    @(negedge clock); #1;
    w0 = writes; c0 = compares; d0 = done_cnt;
    base = b; count = c; mode = m; seed = s; start = 1'b1;
    c_st = cyc + 1;
    @(negedge clock); #1;
    start = 1'b0;
    guard = 0;
    while (done_cnt == d0 && guard < 10000) begin
      // A start pulse while busy must be ignored.
      if (bump && guard == 4) begin
        base = ~b; count = 13'd3; seed = ~s; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock); #1;
      guard++;
    end
    start = 1'b0;
    check({tag, " done seen"}, 32'(guard < 10000), 1);
    check({tag, " done cycle"}, done_cyc - c_st, (n == 0) ? 1 : 2 * n);
    repeat (3) @(negedge clock);
    #1;
    check({tag, " done pulses"}, done_cnt - d0, 1);
    check({tag, " writes"}, writes - w0, n);
    check({tag, " compares"}, compares - c0, n);
    check({tag, " busy after"}, busy, 0);
    check({tag, " error"}, error, 32'(exp_errs != 0));
    check({tag, " err_count"}, err_count, exp_errs);
    if (exp_errs != 0) check({tag, " err_address"}, err_address, exp_eaddr);
    bad = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== exp_ram[i]) bad++;
    check({tag, " ram image"}, bad, 0);
    fault_en = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rb, rf;
    logic [12:0] rc;
    logic [1:0]  rm;
    logic [15:0] rs;
    int w0, d0;

    for (int i = 0; i < 4096; i++) exp_ram[i] = init_word(i);
    repeat (3) @(negedge clock);
    #1;
    init_req = 1'b0;
    check("reset mem_load", mem_load, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset error", error, 0);
    check("reset err_count", err_count, 0);
    check("reset err_address", err_address, 0);
    check("reset mem_address", mem_address, 0);
    check("reset mem_in", mem_in, 0);
    @(negedge clock);
    reset_n = 1'b1;

    run_case("incr", 12'd0, 13'd16, 2'd1, 16'd100, 1'b0, 12'd0, 1'b1);
    check("incr word15", ram[15], 16'd115);
    run_case("wrap", 12'd4090, 13'd10, 2'd0, 16'h5A5A, 1'b0, 12'd0, 1'b0);
    run_case("fault", 12'd0, 13'd16, 2'd0, 16'd1, 1'b1, 12'd7, 1'b0);

    // abort in IDLE leaves the error record alone
    @(negedge clock); #1; abort = 1'b1;
    @(negedge clock); #1; abort = 1'b0;
    check("idle abort error", error, 1);
    check("idle abort err_count", err_count, 1);
    check("idle abort err_address", err_address, 7);

    // start together with abort in IDLE is not accepted
    w0 = writes; d0 = done_cnt;
    base = 12'd500; count = 13'd5; mode = 2'd1; seed = 16'd9; start = 1'b1; abort = 1'b1;
    @(negedge clock); #1; start = 1'b0; abort = 1'b0;
    check("start+abort busy", busy, 0);
    repeat (12) @(negedge clock);
    #1;
    check("start+abort writes", writes - w0, 0);
    check("start+abort done", done_cnt - d0, 0);
    check("start+abort error kept", error, 1);

    run_case("zero", 12'd100, 13'd0, 2'd1, 16'd5, 1'b0, 12'd0, 1'b0);
    check("zero clears error", error, 0);
    run_case("sat", 12'd300, 13'd5000, 2'd1, 16'hFFF0, 1'b0, 12'd0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rb = 12'($urandom_range(0, 4095));
      rc = 13'($urandom_range(1, 48));
      rm = 2'($urandom_range(0, 3));
      rs = 16'($urandom);
      rf = rb + 12'($urandom_range(0, int'(rc) - 1));
      run_case("rnd", rb, rc, rm, rs, r[0], rf, 1'b0);
    end

    // abort during FILL at word 3
    w0 = writes; d0 = done_cnt;
    base = 12'd1000; count = 13'd16; mode = 2'd1; seed = 16'h0010; start = 1'b1;
    @(negedge clock); #1; start = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("abort fill load", mem_load, 1);
    abort = 1'b1;
    @(negedge clock); #1; abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort mem_load", mem_load, 0);
    check("abort writes", writes - w0, 4);
    for (int k = 0; k < 4; k++) exp_ram[1000 + k] = 16'h0010 + 16'(k);
    repeat (40) @(negedge clock);
    #1;
    check("abort no done", done_cnt - d0, 0);

    // reset during FILL drops mem_load at once
    d0 = done_cnt;
    base = 12'd2000; count = 13'd16; mode = 2'd0; seed = 16'h7777; start = 1'b1;
    @(negedge clock); #1; start = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst fill load", mem_load, 1);
    reset_n = 1'b0;
    #1;
    check("rst fill mem_load", mem_load, 0);
    check("rst fill busy", busy, 0);
    exp_ram[2000] = 16'h7777;
    exp_ram[2001] = 16'h7777;
    @(negedge clock); reset_n = 1'b1;

    // reset during VERIFY
    base = 12'd3000; count = 13'd8; mode = 2'd1; seed = 16'd5; start = 1'b1;
    @(negedge clock); #1; start = 1'b0;
    repeat (10) @(negedge clock);
    #1;
    check("rst verify busy pre", busy, 1);
    check("rst verify load pre", mem_load, 0);
    reset_n = 1'b0;
    #1;
    check("rst verify busy", busy, 0);
    check("rst verify mem_load", mem_load, 0);
    for (int k = 0; k < 8; k++) exp_ram[3000 + k] = 16'd5 + 16'(k);
    @(negedge clock); reset_n = 1'b1;
    repeat (30) @(negedge clock);
    #1;
    check("rst no done", done_cnt - d0, 0);
    check("rst mem_address", mem_address, 0);
    check("rst err_count", err_count, 0);

    run_case("mode2", 12'd50, 13'd8, 2'd2, 16'h0, 1'b0, 12'd0, 1'b0);
`ifdef FILL_LFSR_EN
    check("lfsr first word", ram[50], 16'hACE1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
